// File: rtl/bsg_fifo_periodic_buffer.sv
// bsg_fifo_periodic_buffer: circular FIFO that buffers a fast-side stream ahead
// of a bsg_fifo_periodic a-side whose accept window opens only every N cycles.
//
// Ports:
//   clk_i        - single clock, all state updates on its rising edge
//   reset_n_i    - asynchronous active-low reset, discards all entries
//   v_i/data_i   - upstream valid and payload
//   ready_and_o  - buffer can accept (enqueue = v_i & ready_and_o)
//   v_o/data_o   - head valid and payload toward the periodic a-side
//   ready_and_i  - downstream accepts (dequeue = v_o & ready_and_i)
//   count_o      - current occupancy, 0..els_p
//
// Optional feature macro: BSG_FIFO_PERIODIC_BUFFER_BYPASS_EN
//   defined   - an empty buffer forwards v_i/data_i straight to v_o/data_o;
//               a word accepted downstream in that cycle is never stored.
//   undefined - outputs come only from storage (one cycle fill latency).

module bsg_fifo_periodic_buffer #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       ready_and_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       ready_and_i,
    output logic [$clog2(els_p+1)-1:0] count_o
);

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);

    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(els_p);

    logic [ptr_w-1:0]   wr_ptr_r;
    logic [ptr_w-1:0]   rd_ptr_r;
    logic [cnt_w-1:0]   count_r;

    // Held low through reset and set on the first edge after release, so the
    // buffer only starts accepting once the clock domain is running again.
    logic               up_r;

    logic [width_p-1:0] mem_r [els_p];

    logic               empty;
    logic               full;
    logic               enq;
    logic               deq;
    logic               pass;
    logic               wr_en;
    logic               rd_adv;

    assign empty = (count_r == '0);
    assign full  = (count_r == full_cnt);

    // Depends only on registered state: no path from v_i or ready_and_i.
    assign ready_and_o = up_r & ~full;
    assign enq         = v_i & ready_and_o;

`ifdef BSG_FIFO_PERIODIC_BUFFER_BYPASS_EN
    logic byp;

    // An empty buffer presents the incoming word directly; the same-cycle
    // downstream accept then consumes it without touching storage.
    assign byp    = up_r & empty & v_i;
    assign v_o    = ~empty | byp;
    assign data_o = empty ? data_i : mem_r[rd_ptr_r];
    assign pass   = byp & ready_and_i;
`else
    assign v_o    = ~empty;
    assign data_o = mem_r[rd_ptr_r];
    assign pass   = 1'b0;
`endif

    assign deq    = v_o & ready_and_i;
    assign wr_en  = enq & ~pass;
    assign rd_adv = deq & ~pass;

    assign count_o = count_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            up_r <= 1'b0;
        end else begin
            up_r <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
        end else if (wr_en) begin
            wr_ptr_r <= (wr_ptr_r == last_ptr) ? '0 : wr_ptr_r + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_r <= '0;
        end else if (rd_adv) begin
            rd_ptr_r <= (rd_ptr_r == last_ptr) ? '0 : rd_ptr_r + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else begin
            unique case ({wr_en, rd_adv})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage carries no reset; entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

endmodule

// File: doc/bsg_fifo_periodic_buffer.md
BSG_FIFO_PERIODIC_BUFFER -- requirements
Module: bsg_fifo_periodic_buffer

Interface
REQ-001 Parameter width_p, default 8: payload width in bits, >=1.
REQ-002 Parameter els_p, default 4: buffer depth in entries, power of two, >=2.
REQ-003 Port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port v_i, input, 1 bit: upstream data valid.
REQ-006 Port data_i, input, width_p bits: upstream payload.
REQ-007 Port ready_and_o, output, 1 bit: buffer can accept; enqueue = v_i & ready_and_o.
REQ-008 Port v_o, output, 1 bit: head entry valid toward the bsg_fifo_periodic a-side.
REQ-009 Port data_o, output, width_p bits: head payload.
REQ-010 Port ready_and_i, input, 1 bit: downstream accepts; dequeue = v_o & ready_and_i.
REQ-011 Port count_o, output, $clog2(els_p+1) bits: current occupancy.

Function
REQ-012 Storage SHALL be a circular buffer with write pointer, read pointer and occupancy counter, each log2(els_p) bits (counter $clog2(els_p+1)).
REQ-013 Pointers SHALL wrap from els_p-1 to 0 with no skipped or repeated index.
REQ-014 ready_and_o SHALL equal (count != els_p) and SHALL NOT depend combinationally on ready_and_i or v_i.
REQ-015 v_o SHALL equal (count != 0), except in bypass (REQ-024).
REQ-016 data_o SHALL present the entry at the read pointer; its value is don't-care while v_o=0.
REQ-017 Enqueue SHALL write data_i at the write pointer and advance it by one; dequeue SHALL advance the read pointer by one.
REQ-018 Count: +1 on enqueue only, -1 on dequeue only, unchanged on simultaneous enqueue and dequeue or on neither.
REQ-019 Simultaneous enqueue and dequeue SHALL be legal at any occupancy from 1 to els_p-1; when full, enqueue is blocked by ready_and_o=0 even if a dequeue occurs in the same cycle.
REQ-020 Enqueue-to-v_o latency SHALL be 1 cycle when empty (bypass disabled); order SHALL be strict FIFO.
REQ-021 v_o and data_o SHALL hold stable while v_o=1 and ready_and_i=0, so that a periodic downstream window opening every N fast cycles observes the same head.
REQ-022 v_i or ready_and_i toggling while the corresponding handshake is not granted SHALL NOT alter state.

Reset
REQ-023 While reset_n_i=0: pointers=0, count_o=0, v_o=0, ready_and_o=0; storage contents undefined. ready_and_o SHALL rise on the first clk_i edge after reset_n_i is deasserted. Reset asserted mid-operation SHALL discard all entries immediately.

Configuration
REQ-024 Macro BSG_FIFO_PERIODIC_BUFFER_BYPASS_EN defined: when count=0 and v_i=1, v_o=1 and data_o=data_i combinationally; if ready_and_i=1 that cycle, the word passes through, no storage write, count stays 0.
REQ-025 Macro BSG_FIFO_PERIODIC_BUFFER_BYPASS_EN undefined: no combinational path from v_i/data_i to v_o/data_o; REQ-020 latency applies.

Verification
REQ-026 Reset: hold reset_n_i=0 with v_i=1 -> v_o=0, ready_and_o=0, count_o=0; release -> ready_and_o=1 next edge.
REQ-027 Fill/drain els_p=4: enqueue 0xA1..0xA4 with ready_and_i=0 -> count_o=4, ready_and_o=0; a fifth push is ignored; drain -> 0xA1,0xA2,0xA3,0xA4 in order, then v_o=0.
REQ-028 Wrap: stream 10 words 0x00..0x09 with ready_and_i=1 every third cycle -> all 10 received in order, count_o never exceeds 4.
REQ-029 Simultaneous: count=2, enqueue 0x55 and dequeue the same cycle -> count_o stays 2, next output is the old second entry.
REQ-030 Bypass defined: empty, v_i=1, data_i=0x3C, ready_and_i=1 -> v_o=1 and data_o=0x3C same cycle, count_o=0 after edge; undefined: v_o=0 that cycle, v_o=1 and data_o=0x3C one cycle later.
REQ-031 Mid-operation reset: count=3, pulse reset_n_i low between edges -> count_o=0 and v_o=0 asynchronously; no stale word emitted afterward.
